// File: rtl/wb_regfile_pkg.sv
// Shared widths and types for the write-back stage and its register file.
package wb_regfile_pkg;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    localparam reg_idx_t REG_ZERO = ADDR_W'(0);
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB inputs, ID read ports and forwarding/debug outputs of the write-back stage.
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    logic     wbWriteBack;
    logic     wbMemRead;
    reg_idx_t wbDestReg;
    word_t    wbALURes;
    word_t    wbMemData;
    reg_idx_t readReg1;
    reg_idx_t readReg2;
    word_t    readData1;
    word_t    readData2;
    logic     fwdValid;
    reg_idx_t fwdReg;
    word_t    fwdData;
    cnt_t     retiredCount;

    modport master (
        output wbWriteBack, wbMemRead, wbDestReg, wbALURes, wbMemData, readReg1, readReg2,
        input  readData1, readData2, fwdValid, fwdReg, fwdData, retiredCount
    );

    modport slave (
        input  wbWriteBack, wbMemRead, wbDestReg, wbALURes, wbMemData, readReg1, readReg2,
        output readData1, readData2, fwdValid, fwdReg, fwdData, retiredCount
    );
endinterface

// File: rtl/wb_regfile_regfile_2r1w.sv
// Architectural register storage: one synchronous write port, two asynchronous read ports,
// register 0 hardwired to zero, synchronous clear on rst.
module wb_regfile_regfile_2r1w
    import wb_regfile_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     we,
    input  reg_idx_t waddr,
    input  word_t    wdata,
    input  reg_idx_t raddr1,
    input  reg_idx_t raddr2,
    output word_t    rdata1,
    output word_t    rdata2
);
    word_t regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == REG_ZERO) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == REG_ZERO) ? '0 : regs[raddr2];
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, commit qualification, read bypass, EX forwarding
// and a retired-write counter around the 2R1W register file.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    word_t result;
    logic  we;
    word_t rf_data1;
    word_t rf_data2;
    cnt_t  count_q;

    // wbWriteBack gates first so an unknown index on an idle slot cannot enable a write.
    always_comb begin
        result = bus.wbMemRead ? bus.wbMemData : bus.wbALURes;
        we     = bus.wbWriteBack && (bus.wbDestReg != REG_ZERO);
    end

    wb_regfile_regfile_2r1w u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (bus.wbDestReg),
        .wdata  (result),
        .raddr1 (bus.readReg1),
        .raddr2 (bus.readReg2),
        .rdata1 (rf_data1),
        .rdata2 (rf_data2)
    );

    // Same-cycle write-through so ID sees the value being committed this cycle.
    always_comb begin
        bus.readData1 = rf_data1;
        bus.readData2 = rf_data2;
        if (bus.readReg1 == REG_ZERO) begin
            bus.readData1 = '0;
        end else if (we && (bus.readReg1 == bus.wbDestReg)) begin
            bus.readData1 = result;
        end
        if (bus.readReg2 == REG_ZERO) begin
            bus.readData2 = '0;
        end else if (we && (bus.readReg2 == bus.wbDestReg)) begin
            bus.readData2 = result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (we) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.fwdValid     = we;
    assign bus.fwdReg       = bus.wbDestReg;
    assign bus.fwdData      = result;
    assign bus.retiredCount = count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    wb_regfile_if bus();

    wb_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic m, input logic [4:0] d,
                         input logic [31:0] a, input logic [31:0] md,
                         input logic [4:0] r1, input logic [4:0] r2);
        bus.wbWriteBack = w;
        bus.wbMemRead   = m;
        bus.wbDestReg   = d;
        bus.wbALURes    = a;
        bus.wbMemData   = md;
        bus.readReg1    = r1;
        bus.readReg2    = r2;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;

        // Preload two registers, then pulse reset
        drive(1, 0, 4, 32'h44, 0, 0, 0);
        tick();
        drive(1, 0, 6, 32'h66, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 4, 6);
        check_eq("preload_r4", bus.readData1, 32'h44);
        check_eq("preload_cnt", bus.retiredCount, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 4, 6);
        check_eq("rst_rd1", bus.readData1, 32'h0);
        check_eq("rst_rd2", bus.readData2, 32'h0);
        check_eq("rst_cnt", bus.retiredCount, 32'd0);
        check_eq("rst_fwdv", 32'(bus.fwdValid), 32'd0);

        // ALU commit with same-cycle bypass
        drive(1, 0, 5, 32'hDEADBEEF, 32'h0BAD0BAD, 5, 0);
        check_eq("alu_bypass", bus.readData1, 32'hDEADBEEF);
        check_eq("alu_fwdv", 32'(bus.fwdValid), 32'd1);
        check_eq("alu_fwdreg", 32'(bus.fwdReg), 32'd5);
        check_eq("alu_fwddata", bus.fwdData, 32'hDEADBEEF);
        tick();
        drive(0, 0, 0, 0, 0, 5, 0);
        check_eq("alu_stored", bus.readData1, 32'hDEADBEEF);
        check_eq("alu_cnt", bus.retiredCount, 32'd1);

        // Load commit selects memory data
        drive(1, 1, 9, 32'hFFFF0000, 32'h12345678, 0, 9);
        check_eq("ld_fwddata", bus.fwdData, 32'h12345678);
        check_eq("ld_bypass", bus.readData2, 32'h12345678);
        tick();
        drive(0, 0, 0, 0, 0, 9, 5);
        check_eq("ld_stored", bus.readData1, 32'h12345678);
        check_eq("ld_keep_r5", bus.readData2, 32'hDEADBEEF);
        check_eq("ld_cnt", bus.retiredCount, 32'd2);

        // Write to R0 is dropped
        drive(1, 0, 0, 32'h1, 0, 0, 0);
        check_eq("r0_rd2", bus.readData2, 32'h0);
        check_eq("r0_fwdv", 32'(bus.fwdValid), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check_eq("r0_rd1", bus.readData1, 32'h0);
        check_eq("r0_cnt", bus.retiredCount, 32'd2);

        // memRead without writeBack: forwarded data only, no commit
        drive(0, 1, 9, 32'h0, 32'h0000CAFE, 9, 0);
        check_eq("nowb_fwddata", bus.fwdData, 32'h0000CAFE);
        check_eq("nowb_fwdv", 32'(bus.fwdValid), 32'd0);
        check_eq("nowb_nobypass", bus.readData1, 32'h12345678);
        tick();
        drive(0, 0, 0, 0, 0, 9, 0);
        check_eq("nowb_r9", bus.readData1, 32'h12345678);
        check_eq("nowb_cnt", bus.retiredCount, 32'd2);

        // Unknown destination while idle
        drive(0, 0, 5'bx, 32'hBAD0BAD0, 32'hBAD0BAD0, 5, 9);
        tick();
        drive(0, 0, 0, 0, 0, 5, 9);
        check_eq("xdest_r5", bus.readData1, 32'hDEADBEEF);
        check_eq("xdest_r9", bus.readData2, 32'h12345678);

        // Dual bypass on both ports, then an idle slot aimed at the same register
        drive(1, 0, 7, 32'h77, 0, 7, 7);
        check_eq("dual_rd1", bus.readData1, 32'h77);
        check_eq("dual_rd2", bus.readData2, 32'h77);
        tick();
        drive(0, 0, 7, 32'h0, 32'h0, 7, 7);
        check_eq("idle7_rd1", bus.readData1, 32'h77);
        tick();
        drive(0, 0, 0, 0, 0, 7, 0);
        check_eq("idle7_kept", bus.readData1, 32'h77);
        check_eq("idle7_cnt", bus.retiredCount, 32'd3);

        // Reset wins over a simultaneous write
        rst = 1'b1;
        drive(1, 0, 3, 32'hA5A5A5A5, 0, 0, 0);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 3, 7);
        check_eq("rstw_r3", bus.readData1, 32'h0);
        check_eq("rstw_r7", bus.readData2, 32'h0);
        check_eq("rstw_cnt", bus.retiredCount, 32'd0);

        // Commits resume on the first edge after reset
        drive(1, 0, 3, 32'h33, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 3, 0);
        check_eq("resume_r3", bus.readData1, 32'h33);
        check_eq("resume_cnt", bus.retiredCount, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
